// File: rtl/scan_pattern_sequencer.sv
// scan_pattern_sequencer
//   Runs one ATPG pattern at a time through a single-chain scan core. Each pattern goes
//   through the same steps: serial load, one functional capture clock, serial unload.
//   The unloaded chain state and the captured POs are returned on a valid/ready port.
// Ports
//   CK, rst_n              clock (rising edge), asynchronous active-low reset
//   pat_valid/pat_ready    pattern handshake; pat_pi and pat_scan are latched on accept
//   dut_pi, dut_po         PI drive to the core (registered) and PO sample from the core
//   test_se/test_si        registered scan enable and scan serial-in
//   test_so                scan serial-out from the core
//   rsp_valid/rsp_ready    response handshake carrying rsp_state and rsp_po
//   pat_cnt                number of completed responses, 16-bit wrapping
//   busy                   high while a pattern is in LOAD, CAPTURE or UNLOAD
module scan_pattern_sequencer #(
  parameter int unsigned CHAIN_LEN = 179,
  parameter int unsigned NUM_PI    = 35,
  parameter int unsigned NUM_PO    = 49
) (
  input  logic                 CK,
  input  logic                 rst_n,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [NUM_PI-1:0]    pat_pi,
  input  logic [CHAIN_LEN-1:0] pat_scan,
  output logic [NUM_PI-1:0]    dut_pi,
  input  logic [NUM_PO-1:0]    dut_po,
  output logic                 test_se,
  output logic                 test_si,
  input  logic                 test_so,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_state,
  output logic [NUM_PO-1:0]    rsp_po,
  output logic [15:0]          pat_cnt,
  output logic                 busy
);

  localparam int unsigned CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_CAPTURE = 3'd2,
    S_UNLOAD  = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 cnt_last;
  // The MSB of the load vector goes straight to test_si on accept, so only
  // the remaining CHAIN_LEN-1 bits need to be kept for shifting.
  logic [CHAIN_LEN-2:0] load_sr;
  // Holds the first CHAIN_LEN-1 unloaded bits; the last one comes from test_so directly.
  logic [CHAIN_LEN-2:0] unload_sr;
  logic [CHAIN_LEN-1:0] unload_next;

  assign cnt_last    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign unload_next = {unload_sr, test_so};

  // State register
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (pat_valid) state_next = S_LOAD;
      S_LOAD:    if (cnt_last)  state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_UNLOAD;
      S_UNLOAD:  if (cnt_last)  state_next = S_RESP;
      S_RESP:    if (rsp_ready) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    pat_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE:                     pat_ready = 1'b1;
      S_LOAD, S_CAPTURE, S_UNLOAD: busy     = 1'b1;
      default: ;
    endcase
  end

  // Scan datapath, bit counter and registered outputs
  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      load_sr   <= '0;
      unload_sr <= '0;
      dut_pi    <= '0;
      test_se   <= 1'b0;
      test_si   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_state <= '0;
      rsp_po    <= '0;
      pat_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pat_valid) begin
            load_sr <= pat_scan[CHAIN_LEN-2:0];
            dut_pi  <= pat_pi;
            test_se <= 1'b1;
            test_si <= pat_scan[CHAIN_LEN-1];
            bit_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (cnt_last) begin
            test_se <= 1'b0;
            test_si <= 1'b0;
            bit_cnt <= '0;
          end else begin
            test_si <= load_sr[CHAIN_LEN-2];
            load_sr <= load_sr << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          rsp_po  <= dut_po;
          test_se <= 1'b1;
        end
        S_UNLOAD: begin
          unload_sr <= unload_next[CHAIN_LEN-2:0];
          if (cnt_last) begin
            // The final sample is taken on this same edge, so publish the full vector now.
            rsp_state <= unload_next;
            rsp_valid <= 1'b1;
            test_se   <= 1'b0;
            pat_cnt   <= pat_cnt + 16'd1;
            bit_cnt   <= '0;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_pattern_sequencer.sv
// Bench for scan_pattern_sequencer: a behavioural scan core (single chain, selectable
// capture function) sits behind the sequencer; expected responses come from the
// pattern and capture rule directly and are queued for a separate response monitor.
`timescale 1ns/1ps
module tb_scan_pattern_sequencer;

  localparam int L      = 179;
  localparam int NUM_PI = 35;
  localparam int NUM_PO = 49;

  logic              CK = 1'b0;
  logic              rst_n;
  logic              pat_valid;
  logic              pat_ready;
  logic [NUM_PI-1:0] pat_pi;
  logic [L-1:0]      pat_scan;
  logic [NUM_PI-1:0] dut_pi;
  logic [NUM_PO-1:0] dut_po;
  logic              test_se;
  logic              test_si;
  logic              test_so;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [L-1:0]      rsp_state;
  logic [NUM_PO-1:0] rsp_po;
  logic [15:0]       pat_cnt;
  logic              busy;

  always #5 CK = ~CK;

  scan_pattern_sequencer #(.CHAIN_LEN(L), .NUM_PI(NUM_PI), .NUM_PO(NUM_PO)) dut (
    .CK(CK), .rst_n(rst_n),
    .pat_valid(pat_valid), .pat_ready(pat_ready), .pat_pi(pat_pi), .pat_scan(pat_scan),
    .dut_pi(dut_pi), .dut_po(dut_po),
    .test_se(test_se), .test_si(test_si), .test_so(test_so),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_state(rsp_state), .rsp_po(rsp_po),
    .pat_cnt(pat_cnt), .busy(busy)
  );

  // Scan core: mode 0 capture holds, mode 1 inverts every flop, mode 2 rotates left by one.
  logic [L-1:0] chain;
  int           core_mode = 0;

  always @(posedge CK) begin
    if (test_se) chain <= {chain[L-2:0], test_si};
    else begin
      case (core_mode)
        1:       chain <= ~chain;
        2:       chain <= {chain[L-2:0], chain[L-1]};
        default: ;
      endcase
    end
  end

  assign test_so = chain[L-1];

  always_comb begin
    dut_po = chain[NUM_PO-1:0];
    if (core_mode != 1) dut_po = chain[NUM_PO-1:0] ^ NUM_PO'(dut_pi);
  end

  typedef struct packed {
    logic [L-1:0]      state;
    logic [NUM_PO-1:0] po;
    logic [15:0]       cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // After a full load the chain equals the pattern; the capture rule then gives the unload.
  function automatic logic [L-1:0] model_state(input logic [L-1:0] scan, input int mode);
    case (mode)
      1:       return ~scan;
      2:       return {scan[L-2:0], scan[L-1]};
      default: return scan;
    endcase
  endfunction

  function automatic logic [NUM_PO-1:0] model_po(input logic [L-1:0] scan,
                                                 input logic [NUM_PI-1:0] pi, input int mode);
    if (mode == 1) return scan[NUM_PO-1:0];
    return scan[NUM_PO-1:0] ^ NUM_PO'(pi);
  endfunction

  function automatic logic [L-1:0] rand_scan();
    logic [191:0] r;
    for (int i = 0; i < 6; i++) r[i*32 +: 32] = $urandom();
    return r[L-1:0];
  endfunction

  function automatic logic [NUM_PI-1:0] rand_pi();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[NUM_PI-1:0];
  endfunction

  // Offer a pattern at the current falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic [L-1:0] scan, input logic [NUM_PI-1:0] pi, input int mode,
                       input bit push, input bit keep_valid, output int waited);
    exp_t e;
    pat_valid = 1'b1;
    pat_scan  = scan;
    pat_pi    = pi;
    core_mode = mode;
    waited    = -1;
    for (int i = 0; i < 500; i++) begin
      if (pat_ready === 1'b1) begin
        waited = i;
        break;
      end
      @(negedge CK);
    end
    if (waited < 0) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout pat_ready=%b required=1", pat_ready);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
    end
    if (push) begin
      exp_cnt = exp_cnt + 16'd1;
      e.state = model_state(scan, mode);
      e.po    = model_po(scan, pi, mode);
      e.cnt   = exp_cnt;
      exp_q.push_back(e);
    end
    @(negedge CK);
    if (!keep_valid) pat_valid = 1'b0;
  endtask

  // Follow a pattern from cycle 1 through the response handshake into the next IDLE cycle.
  task automatic follow(input logic [L-1:0] scan, input logic [NUM_PI-1:0] pi, input int mode,
                        input int hold, input bit pend, input string tag);
    logic [L-1:0]      sh;
    logic [L-1:0]      es;
    logic [NUM_PO-1:0] ep;
    int                se_bad = 0;
    int                si_bad = 0;
    int                aux_bad = 0;
    int                stab_bad = 0;
    bit                exp_se;
    bit                exp_si;
    sh = scan;
    es = model_state(scan, mode);
    ep = model_po(scan, pi, mode);
    for (int k = 1; k <= 2*L+1; k++) begin
      exp_se = (k != L+1);
      exp_si = (k <= L) ? sh[L-1] : 1'b0;
      sh = sh << 1;
      if (test_se !== exp_se) se_bad++;
      if (test_si !== exp_si) si_bad++;
      if (rsp_valid !== 1'b0 || pat_ready !== 1'b0 || busy !== 1'b1 || dut_pi !== pi) aux_bad++;
      @(negedge CK);
    end
    check({tag, "_se_timeline"}, 256'(se_bad), 256'(0));
    check({tag, "_si_timeline"}, 256'(si_bad), 256'(0));
    check({tag, "_busy_window"}, 256'(aux_bad), 256'(0));
    check({tag, "_rsp_valid_latency"}, 256'(rsp_valid), 256'(1));
    if (pend) begin
      pat_valid = 1'b1;
      pat_scan  = rand_scan();
      pat_pi    = rand_pi();
    end
    for (int h = 0; h <= hold; h++) begin
      if (rsp_valid !== 1'b1 || rsp_state !== es || rsp_po !== ep || pat_ready !== 1'b0 ||
          busy !== 1'b0 || test_se !== 1'b0 || dut_pi !== pi) stab_bad++;
      if (h < hold) @(negedge CK);
    end
    check({tag, "_rsp_hold"}, 256'(stab_bad), 256'(0));
    if (pend) pat_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CK);
    rsp_ready = 1'b0;
    check({tag, "_idle_valid"}, 256'(rsp_valid), 256'(0));
    check({tag, "_idle_ready"}, 256'(pat_ready), 256'(1));
    check({tag, "_pat_cnt"}, 256'(pat_cnt), 256'(exp_cnt));
    check({tag, "_dut_pi_held"}, 256'(dut_pi), 256'(pi));
  endtask

  // Response monitor: compares every response handshake against the queued expectation.
  always begin
    exp_t e;
    @(negedge CK);
    #1;
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response rsp_state=%0h required=none", rsp_state);
      end else begin
        e = exp_q.pop_front();
        check("mon_rsp_state", 256'(rsp_state), 256'(e.state));
        check("mon_rsp_po", 256'(rsp_po), 256'(e.po));
        check("mon_pat_cnt", 256'(pat_cnt), 256'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached required=finish");
    $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
    $fatal(1);
  end

  initial begin
    logic [L-1:0]      s;
    logic [L-1:0]      s2;
    logic [NUM_PI-1:0] p;
    logic [NUM_PI-1:0] p2;
    int                w;
    int                m;
    int                bad;

    // Reset with handshake inputs active: they must be ignored.
    rst_n     = 1'b0;
    pat_valid = 1'b1;
    pat_scan  = '1;
    pat_pi    = '1;
    rsp_ready = 1'b1;
    repeat (3) @(negedge CK);
    check("rst_test_se", 256'(test_se), 256'(0));
    check("rst_test_si", 256'(test_si), 256'(0));
    check("rst_dut_pi", 256'(dut_pi), 256'(0));
    check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    check("rst_pat_ready", 256'(pat_ready), 256'(1));
    check("rst_pat_cnt", 256'(pat_cnt), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_rsp_state", 256'(rsp_state), 256'(0));
    check("rst_rsp_po", 256'(rsp_po), 256'(0));
    pat_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge CK);
    rst_n = 1'b1;
    @(negedge CK);
    check("post_rst_ready", 256'(pat_ready), 256'(1));

    // Alternating pattern through a hold-capture chain.
    for (int i = 0; i < L; i++) s[i] = ((L - 1 - i) % 2) == 0;
    p = 35'h5_A5A5_A5A5;
    issue(s, p, 0, 1'b1, 1'b0, w);
    check("alt_dut_pi", 256'(dut_pi), 256'(p));
    follow(s, p, 0, 3, 1'b0, "alt");

    // All-ones pattern through an inverting capture; POs reflect the loaded chain.
    s = '1;
    p = rand_pi();
    issue(s, p, 1, 1'b1, 1'b0, w);
    follow(s, p, 1, 2, 1'b0, "inv");

    // 100 cycles of response backpressure with a competing pattern on offer.
    s = rand_scan();
    p = rand_pi();
    issue(s, p, 2, 1'b1, 1'b0, w);
    follow(s, p, 2, 100, 1'b1, "bp");

    // Randomized patterns, capture rules and backpressure.
    for (int n = 0; n < 6; n++) begin
      s = rand_scan();
      p = rand_pi();
      m = int'($urandom_range(0, 2));
      issue(s, p, m, 1'b1, 1'b0, w);
      follow(s, p, m, int'($urandom_range(0, 5)), 1'b0, $sformatf("rnd%0d", n));
    end

    // rsp_ready without a response has no effect.
    rsp_ready = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge CK);
      if (rsp_valid !== 1'b0 || pat_ready !== 1'b1 || pat_cnt !== exp_cnt) bad++;
    end
    rsp_ready = 1'b0;
    check("ready_no_valid", 256'(bad), 256'(0));

    // Reset during LOAD cycle 50 aborts the pattern.
    s = rand_scan();
    p = rand_pi();
    issue(s, p, 0, 1'b0, 1'b0, w);
    repeat (49) @(negedge CK);
    check("abort_pre_se", 256'(test_se), 256'(1));
    rst_n = 1'b0;
    #1;
    check("abort_se_async", 256'(test_se), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_ready", 256'(pat_ready), 256'(1));
    check("abort_dut_pi", 256'(dut_pi), 256'(0));
    check("abort_cnt", 256'(pat_cnt), 256'(0));
    exp_cnt = 16'd0;
    @(negedge CK);
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 2*L+20; c++) begin
      @(negedge CK);
      if (rsp_valid !== 1'b0 || pat_ready !== 1'b1 || pat_cnt !== 16'd0) bad++;
    end
    check("abort_no_response", 256'(bad), 256'(0));

    // Back-to-back patterns with pat_valid held high throughout.
    s  = rand_scan();
    p  = rand_pi();
    s2 = rand_scan();
    p2 = rand_pi();
    issue(s, p, 0, 1'b1, 1'b1, w);
    pat_scan = s2;
    pat_pi   = p2;
    follow(s, p, 0, 2, 1'b0, "b2b_a");
    issue(s2, p2, 0, 1'b1, 1'b0, w);
    check("b2b_idle_gap", 256'(w), 256'(0));
    follow(s2, p2, 0, 0, 1'b0, "b2b_b");

    repeat (3) @(negedge CK);
    check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
